// File: rtl/peripheral_bus_splitter_4port_pkg.sv
// peripheral_bus_splitter_4port_pkg: shared FSM states, port count and default address map
package peripheral_bus_splitter_4port_pkg;
  typedef enum logic [1:0] {IDLE, DISPATCH, WAIT_RESP, RESPOND} state_t;
  localparam int NUM_PORTS = 4;
  localparam logic [31:0] DEF_PORT0_BASE = 32'h0000_0000;
  localparam logic [31:0] DEF_PORT1_BASE = 32'h0000_1000;
  localparam logic [31:0] DEF_PORT2_BASE = 32'h0000_2000;
  localparam logic [31:0] DEF_PORT3_BASE = 32'h0000_3000;
  localparam logic [31:0] DEF_PORT_MASK  = 32'hFFFF_F000;
  function automatic logic [1:0] onehot_idx(input logic [NUM_PORTS-1:0] oh);
    logic [1:0] idx;
    idx = '0;
    for (int i = 0; i < NUM_PORTS; i++) if (oh[i]) idx = 2'(i);
    return idx;
  endfunction
endpackage

// File: rtl/peripheral_bus_splitter_4port_if.sv
// peripheral_bus_splitter_4port_if: master request/response and four-port fan-out signals
interface peripheral_bus_splitter_4port_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);
  import peripheral_bus_splitter_4port_pkg::*;
  logic                            bus_req_valid_i;
  logic                            bus_req_write_i;
  logic [ADDR_WIDTH-1:0]           bus_req_addr_i;
  logic [DATA_WIDTH-1:0]           bus_req_data_i;
  logic                            bus_req_ready_o;
  logic [NUM_PORTS-1:0]            bus_port_valid_o;
  logic                            bus_port_write_o;
  logic [ADDR_WIDTH-1:0]           bus_port_addr_o;
  logic [DATA_WIDTH-1:0]           bus_port_data_o;
  logic [NUM_PORTS-1:0]            bus_port_resp_valid_i;
  logic [NUM_PORTS*DATA_WIDTH-1:0] bus_port_resp_data_i;
  logic                            bus_resp_valid_o;
  logic [DATA_WIDTH-1:0]           bus_resp_data_o;
  logic                            bus_resp_error_o;
  modport master (
    output bus_req_valid_i, bus_req_write_i, bus_req_addr_i, bus_req_data_i,
           bus_port_resp_valid_i, bus_port_resp_data_i,
    input  bus_req_ready_o, bus_port_valid_o, bus_port_write_o, bus_port_addr_o, bus_port_data_o,
           bus_resp_valid_o, bus_resp_data_o, bus_resp_error_o
  );
  modport slave (
    input  bus_req_valid_i, bus_req_write_i, bus_req_addr_i, bus_req_data_i,
           bus_port_resp_valid_i, bus_port_resp_data_i,
    output bus_req_ready_o, bus_port_valid_o, bus_port_write_o, bus_port_addr_o, bus_port_data_o,
           bus_resp_valid_o, bus_resp_data_o, bus_resp_error_o
  );
endinterface

// File: rtl/peripheral_bus_addr_match.sv
// peripheral_bus_addr_match: masked base-address compare, one-hot lowest-index match
module peripheral_bus_addr_match import peripheral_bus_splitter_4port_pkg::*; #(
  parameter int ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] PORT0_BASE = ADDR_WIDTH'(DEF_PORT0_BASE),
  parameter logic [ADDR_WIDTH-1:0] PORT1_BASE = ADDR_WIDTH'(DEF_PORT1_BASE),
  parameter logic [ADDR_WIDTH-1:0] PORT2_BASE = ADDR_WIDTH'(DEF_PORT2_BASE),
  parameter logic [ADDR_WIDTH-1:0] PORT3_BASE = ADDR_WIDTH'(DEF_PORT3_BASE),
  parameter logic [ADDR_WIDTH-1:0] PORT_MASK  = ADDR_WIDTH'(DEF_PORT_MASK)
) (
  input  logic [ADDR_WIDTH-1:0] addr,
  output logic [NUM_PORTS-1:0]  match,
  output logic                  hit
);
  logic [NUM_PORTS-1:0][ADDR_WIDTH-1:0] bases;
  logic [NUM_PORTS-1:0] raw;
  assign bases = {PORT3_BASE, PORT2_BASE, PORT1_BASE, PORT0_BASE};
  for (genvar n = 0; n < NUM_PORTS; n++) begin : g_cmp
    assign raw[n] = (addr & PORT_MASK) == (bases[n] & PORT_MASK);
  end
  // two's-complement trick isolates the lowest set bit when windows overlap
  assign match = raw & -raw;
  assign hit = |raw;
endmodule

// File: rtl/peripheral_bus_splitter_4port.sv
// peripheral_bus_splitter_4port: routes one master request to one of four ports by address.
// Define W0RM_BUS_SPLITTER_TIMEOUT_EN to bound the response wait to TIMEOUT_CYCLES.
module peripheral_bus_splitter_4port import peripheral_bus_splitter_4port_pkg::*; #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] PORT0_BASE = ADDR_WIDTH'(DEF_PORT0_BASE),
  parameter logic [ADDR_WIDTH-1:0] PORT1_BASE = ADDR_WIDTH'(DEF_PORT1_BASE),
  parameter logic [ADDR_WIDTH-1:0] PORT2_BASE = ADDR_WIDTH'(DEF_PORT2_BASE),
  parameter logic [ADDR_WIDTH-1:0] PORT3_BASE = ADDR_WIDTH'(DEF_PORT3_BASE),
  parameter logic [ADDR_WIDTH-1:0] PORT_MASK  = ADDR_WIDTH'(DEF_PORT_MASK),
  parameter int TIMEOUT_CYCLES = 16
) (
  input logic bus_clock,
  input logic bus_reset,
  peripheral_bus_splitter_4port_if.slave bus
);
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be within 1..255");
  end
  state_t st, nxt;
  logic [NUM_PORTS-1:0] match, port_valid_q;
  logic hit, accept, sel_hit, timeout, write_q, err_q;
  logic [1:0] sel_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] data_q, rdata_q, sel_data;
  peripheral_bus_addr_match #(
    .ADDR_WIDTH(ADDR_WIDTH), .PORT0_BASE(PORT0_BASE), .PORT1_BASE(PORT1_BASE),
    .PORT2_BASE(PORT2_BASE), .PORT3_BASE(PORT3_BASE), .PORT_MASK(PORT_MASK)
  ) u_match (.addr(bus.bus_req_addr_i), .match(match), .hit(hit));
  assign sel_hit  = st == WAIT_RESP && bus.bus_port_resp_valid_i[sel_q];
  assign sel_data = bus.bus_port_resp_data_i[int'(sel_q)*DATA_WIDTH +: DATA_WIDTH];
`ifdef W0RM_BUS_SPLITTER_TIMEOUT_EN
  logic [7:0] wait_cnt;
  always_ff @(posedge bus_clock)
    wait_cnt <= (bus_reset || st != WAIT_RESP) ? 8'd0 : wait_cnt + 8'd1;
  assign timeout = st == WAIT_RESP && wait_cnt == 8'(TIMEOUT_CYCLES - 1);
`else
  assign timeout = 1'b0;
`endif
  always_comb begin
    accept = bus.bus_req_valid_i && st == IDLE;
    nxt = st == IDLE      ? (accept ? (hit ? DISPATCH : RESPOND) : IDLE)
        : st == DISPATCH  ? WAIT_RESP
        : st == WAIT_RESP ? ((sel_hit || timeout) ? RESPOND : WAIT_RESP)
        : IDLE;
  end
  // response data/error are refreshed every WAIT_RESP cycle so the exit cycle leaves the right values
  always_ff @(posedge bus_clock) begin
    if (bus_reset) begin
      st <= IDLE; port_valid_q <= '0; write_q <= 1'b0; addr_q <= '0; data_q <= '0;
      sel_q <= '0; rdata_q <= '0; err_q <= 1'b0;
    end else begin
      st <= nxt;
      port_valid_q <= accept ? match : '0;
      if (accept) begin
        write_q <= bus.bus_req_write_i; addr_q <= bus.bus_req_addr_i; data_q <= bus.bus_req_data_i;
        sel_q <= onehot_idx(match); rdata_q <= '0; err_q <= !hit;
      end else if (st == WAIT_RESP) begin
        rdata_q <= sel_hit ? sel_data : '0;
        err_q <= !sel_hit;
      end
    end
  end
  assign bus.bus_req_ready_o  = st == IDLE;
  assign bus.bus_port_valid_o = port_valid_q;
  assign bus.bus_port_write_o = write_q;
  assign bus.bus_port_addr_o  = addr_q;
  assign bus.bus_port_data_o  = data_q;
  assign bus.bus_resp_valid_o = st == RESPOND;
  assign bus.bus_resp_data_o  = st == RESPOND ? rdata_q : '0;
  assign bus.bus_resp_error_o = st == RESPOND && err_q;
endmodule

// File: tb/tb_peripheral_bus_splitter_4port.sv
// tb_peripheral_bus_splitter_4port: directed tests of decode, dispatch, response, reset and timeout
module tb_peripheral_bus_splitter_4port;
  logic bus_clock = 1'b0;
  logic bus_reset = 1'b1;
  int total = 0;
  int bad = 0;
  always #5 bus_clock = ~bus_clock;
  peripheral_bus_splitter_4port_if bus ();
  peripheral_bus_splitter_4port dut (.bus_clock(bus_clock), .bus_reset(bus_reset), .bus(bus));

  task automatic step(input int n = 1);
    repeat (n) @(posedge bus_clock);
    #1;
  endtask

  task automatic request(input logic wr, input logic [31:0] a, input logic [31:0] d);
    bus.bus_req_valid_i = 1'b1; bus.bus_req_write_i = wr; bus.bus_req_addr_i = a; bus.bus_req_data_i = d;
  endtask

  task automatic drop_req();
    bus.bus_req_valid_i = 1'b0; bus.bus_req_write_i = 1'b0; bus.bus_req_addr_i = '0; bus.bus_req_data_i = '0;
  endtask

  task automatic set_resp(input int p, input logic [31:0] d);
    bus.bus_port_resp_valid_i = 4'b0001 << p;
    bus.bus_port_resp_data_i = '0;
    bus.bus_port_resp_data_i[p*32 +: 32] = d;
  endtask

  task automatic clr_resp();
    bus.bus_port_resp_valid_i = '0; bus.bus_port_resp_data_i = '0;
  endtask

  task automatic test_reset();
    drop_req(); clr_resp();
    bus_reset = 1'b1;
    step(2);
    total++; if (bus.bus_req_ready_o !== 1'b1) begin bad++; $display("FAIL rst_ready got=%0h exp=1", bus.bus_req_ready_o); end
    total++; if (bus.bus_port_valid_o !== 4'b0) begin bad++; $display("FAIL rst_port_valid got=%0h exp=0", bus.bus_port_valid_o); end
    total++; if (bus.bus_resp_valid_o !== 1'b0) begin bad++; $display("FAIL rst_resp_valid got=%0h exp=0", bus.bus_resp_valid_o); end
    total++; if (bus.bus_resp_error_o !== 1'b0) begin bad++; $display("FAIL rst_resp_error got=%0h exp=0", bus.bus_resp_error_o); end
    total++; if (bus.bus_resp_data_o !== 32'h0) begin bad++; $display("FAIL rst_resp_data got=%0h exp=0", bus.bus_resp_data_o); end
    total++; if ({bus.bus_port_addr_o, bus.bus_port_data_o, bus.bus_port_write_o} !== 65'h0) begin bad++; $display("FAIL rst_port_fields got=%0h exp=0", {bus.bus_port_addr_o, bus.bus_port_data_o, bus.bus_port_write_o}); end
    bus_reset = 1'b0;
    step();
  endtask

  task automatic test_read_port1();
    request(1'b0, 32'h0000_1004, 32'h0);
    total++; if (bus.bus_req_ready_o !== 1'b1) begin bad++; $display("FAIL rd_ready_before got=%0h exp=1", bus.bus_req_ready_o); end
    step(); drop_req();
    total++; if (bus.bus_port_valid_o !== 4'b0010) begin bad++; $display("FAIL rd_strobe got=%0h exp=2", bus.bus_port_valid_o); end
    total++; if (bus.bus_port_addr_o !== 32'h0000_1004) begin bad++; $display("FAIL rd_port_addr got=%0h exp=1004", bus.bus_port_addr_o); end
    total++; if (bus.bus_port_write_o !== 1'b0) begin bad++; $display("FAIL rd_port_write got=%0h exp=0", bus.bus_port_write_o); end
    step(); set_resp(1, 32'hDEAD_BEEF);
    total++; if (bus.bus_port_valid_o !== 4'b0) begin bad++; $display("FAIL rd_strobe_one_cycle got=%0h exp=0", bus.bus_port_valid_o); end
    total++; if (bus.bus_resp_valid_o !== 1'b0) begin bad++; $display("FAIL rd_resp_early got=%0h exp=0", bus.bus_resp_valid_o); end
    step(); clr_resp();
    total++; if (bus.bus_resp_valid_o !== 1'b1) begin bad++; $display("FAIL rd_resp_valid got=%0h exp=1", bus.bus_resp_valid_o); end
    total++; if (bus.bus_resp_data_o !== 32'hDEAD_BEEF) begin bad++; $display("FAIL rd_resp_data got=%0h exp=deadbeef", bus.bus_resp_data_o); end
    total++; if (bus.bus_resp_error_o !== 1'b0) begin bad++; $display("FAIL rd_resp_error got=%0h exp=0", bus.bus_resp_error_o); end
    step();
    total++; if (bus.bus_resp_valid_o !== 1'b0) begin bad++; $display("FAIL rd_resp_one_cycle got=%0h exp=0", bus.bus_resp_valid_o); end
    total++; if (bus.bus_resp_data_o !== 32'h0) begin bad++; $display("FAIL rd_resp_data_idle got=%0h exp=0", bus.bus_resp_data_o); end
    total++; if (bus.bus_req_ready_o !== 1'b1) begin bad++; $display("FAIL rd_ready_after got=%0h exp=1", bus.bus_req_ready_o); end
  endtask

  task automatic test_unmapped_write();
    request(1'b1, 32'h0000_9000, 32'h1234_5678);
    step(); drop_req();
    total++; if (bus.bus_port_valid_o !== 4'b0) begin bad++; $display("FAIL um_strobe got=%0h exp=0", bus.bus_port_valid_o); end
    total++; if (bus.bus_resp_valid_o !== 1'b1) begin bad++; $display("FAIL um_resp_valid got=%0h exp=1", bus.bus_resp_valid_o); end
    total++; if (bus.bus_resp_data_o !== 32'h0) begin bad++; $display("FAIL um_resp_data got=%0h exp=0", bus.bus_resp_data_o); end
    total++; if (bus.bus_resp_error_o !== 1'b1) begin bad++; $display("FAIL um_resp_error got=%0h exp=1", bus.bus_resp_error_o); end
    step();
    total++; if ({bus.bus_resp_valid_o, bus.bus_resp_error_o, bus.bus_req_ready_o} !== 3'b001) begin bad++; $display("FAIL um_after got=%0b exp=001", {bus.bus_resp_valid_o, bus.bus_resp_error_o, bus.bus_req_ready_o}); end
  endtask

  task automatic test_select_port2();
    request(1'b1, 32'h0000_2010, 32'h0000_A5A5);
    step(); drop_req();
    total++; if (bus.bus_port_valid_o !== 4'b0100) begin bad++; $display("FAIL p2_strobe got=%0h exp=4", bus.bus_port_valid_o); end
    total++; if ({bus.bus_port_write_o, bus.bus_port_data_o} !== {1'b1, 32'h0000_A5A5}) begin bad++; $display("FAIL p2_port_wr_data got=%0h exp=10000a5a5", {bus.bus_port_write_o, bus.bus_port_data_o}); end
    step(); set_resp(0, 32'h0000_1111);
    step(); set_resp(2, 32'h0000_2222);
    total++; if ({bus.bus_resp_valid_o, bus.bus_req_ready_o} !== 2'b00) begin bad++; $display("FAIL p2_ignore_port0 got=%0b exp=00", {bus.bus_resp_valid_o, bus.bus_req_ready_o}); end
    step(); clr_resp();
    total++; if (bus.bus_resp_valid_o !== 1'b1) begin bad++; $display("FAIL p2_resp_valid got=%0h exp=1", bus.bus_resp_valid_o); end
    total++; if (bus.bus_resp_data_o !== 32'h0000_2222) begin bad++; $display("FAIL p2_resp_data got=%0h exp=2222", bus.bus_resp_data_o); end
    total++; if ({bus.bus_resp_error_o, bus.bus_req_ready_o} !== 2'b00) begin bad++; $display("FAIL p2_err_ready got=%0b exp=00", {bus.bus_resp_error_o, bus.bus_req_ready_o}); end
    step();
    total++; if (bus.bus_req_ready_o !== 1'b1) begin bad++; $display("FAIL p2_ready_after got=%0h exp=1", bus.bus_req_ready_o); end
    total++; if (bus.bus_port_addr_o !== 32'h0000_2010) begin bad++; $display("FAIL p2_addr_hold got=%0h exp=2010", bus.bus_port_addr_o); end
  endtask

  task automatic test_decode_boundaries();
    logic [31:0] addrs [5] = '{32'h0000_0FFC, 32'h0000_1FFF, 32'h0000_3FFC, 32'h0000_4000, 32'hFFFF_3000};
    int ports [5] = '{0, 1, 3, -1, -1};
    logic [3:0] exp_oh;
    for (int i = 0; i < 5; i++) begin
      exp_oh = ports[i] < 0 ? 4'b0 : 4'b0001 << ports[i];
      request(1'b0, addrs[i], 32'h0);
      step(); drop_req();
      total++; if (bus.bus_port_valid_o !== exp_oh) begin bad++; $display("FAIL dec_strobe[%0d] got=%0h exp=%0h", i, bus.bus_port_valid_o, exp_oh); end
      if (ports[i] >= 0) begin
        step(); set_resp(ports[i], addrs[i] ^ 32'h5A5A_0000);
        step(); clr_resp();
        total++; if ({bus.bus_resp_valid_o, bus.bus_resp_error_o, bus.bus_resp_data_o} !== {2'b10, addrs[i] ^ 32'h5A5A_0000}) begin bad++; $display("FAIL dec_resp[%0d] got=%0h exp=%0h", i, {bus.bus_resp_valid_o, bus.bus_resp_error_o, bus.bus_resp_data_o}, {2'b10, addrs[i] ^ 32'h5A5A_0000}); end
      end else begin
        total++; if ({bus.bus_resp_valid_o, bus.bus_resp_error_o} !== 2'b11) begin bad++; $display("FAIL dec_err[%0d] got=%0b exp=11", i, {bus.bus_resp_valid_o, bus.bus_resp_error_o}); end
      end
      step();
    end
  endtask

  task automatic test_reset_mid();
    int resps = 0;
    request(1'b0, 32'h0000_3000, 32'h0);
    step(); drop_req();
    step();
    bus_reset = 1'b1;
    step();
    bus_reset = 1'b0;
    total++; if (bus.bus_req_ready_o !== 1'b1) begin bad++; $display("FAIL rm_ready got=%0h exp=1", bus.bus_req_ready_o); end
    total++; if ({bus.bus_port_valid_o, bus.bus_port_addr_o} !== 36'h0) begin bad++; $display("FAIL rm_port_clear got=%0h exp=0", {bus.bus_port_valid_o, bus.bus_port_addr_o}); end
    set_resp(3, 32'hBAD0_0003);
    for (int c = 0; c < 4; c++) begin
      step();
      if (bus.bus_resp_valid_o) resps++;
    end
    clr_resp();
    total++; if (resps !== 0) begin bad++; $display("FAIL rm_no_resp got=%0d exp=0", resps); end
    total++; if (bus.bus_req_ready_o !== 1'b1) begin bad++; $display("FAIL rm_ready_after got=%0h exp=1", bus.bus_req_ready_o); end
  endtask

  task automatic test_back_to_back();
    int strobes = 0;
    int resps = 0;
    logic [3:0] seen = '0;
    logic [31:0] rdata = '0;
    request(1'b0, 32'h0000_1000, 32'h0);
    step();
    request(1'b0, 32'h0000_2000, 32'h0);
    for (int c = 0; c < 8; c++) begin
      if (bus.bus_port_valid_o != 4'b0) begin strobes++; seen = bus.bus_port_valid_o; end
      if (bus.bus_resp_valid_o) begin resps++; rdata = bus.bus_resp_data_o; end
      if (c == 1) begin drop_req(); set_resp(1, 32'h1234_5678); end
      if (c == 2) clr_resp();
      step();
    end
    total++; if (strobes !== 1) begin bad++; $display("FAIL b2b_strobes got=%0d exp=1", strobes); end
    total++; if (seen !== 4'b0010) begin bad++; $display("FAIL b2b_port got=%0h exp=2", seen); end
    total++; if (resps !== 1) begin bad++; $display("FAIL b2b_resps got=%0d exp=1", resps); end
    total++; if (rdata !== 32'h1234_5678) begin bad++; $display("FAIL b2b_data got=%0h exp=12345678", rdata); end
    total++; if (bus.bus_port_addr_o !== 32'h0000_1000) begin bad++; $display("FAIL b2b_addr got=%0h exp=1000", bus.bus_port_addr_o); end
  endtask

`ifdef W0RM_BUS_SPLITTER_TIMEOUT_EN
  task automatic test_timeout();
    request(1'b0, 32'h0000_3000, 32'h0);
    step(); drop_req();
    step(16);
    total++; if ({bus.bus_resp_valid_o, bus.bus_req_ready_o} !== 2'b00) begin bad++; $display("FAIL to_wait16 got=%0b exp=00", {bus.bus_resp_valid_o, bus.bus_req_ready_o}); end
    step();
    total++; if ({bus.bus_resp_valid_o, bus.bus_resp_error_o, bus.bus_resp_data_o} !== {2'b11, 32'h0}) begin bad++; $display("FAIL to_expire got=%0h exp=%0h", {bus.bus_resp_valid_o, bus.bus_resp_error_o, bus.bus_resp_data_o}, {2'b11, 32'h0}); end
    step();
    request(1'b0, 32'h0000_3004, 32'h0);
    step(); drop_req();
    step(16); set_resp(3, 32'hCAFE_0003);
    step(); clr_resp();
    total++; if ({bus.bus_resp_valid_o, bus.bus_resp_error_o, bus.bus_resp_data_o} !== {2'b10, 32'hCAFE_0003}) begin bad++; $display("FAIL to_resp_wins got=%0h exp=%0h", {bus.bus_resp_valid_o, bus.bus_resp_error_o, bus.bus_resp_data_o}, {2'b10, 32'hCAFE_0003}); end
    step();
  endtask
`else
  task automatic test_timeout();
    int resps = 0;
    request(1'b0, 32'h0000_3000, 32'h0);
    step(); drop_req();
    for (int c = 0; c < 40; c++) begin
      step();
      if (bus.bus_resp_valid_o) resps++;
    end
    total++; if (resps !== 0) begin bad++; $display("FAIL nt_no_expiry got=%0d exp=0", resps); end
    total++; if (bus.bus_req_ready_o !== 1'b0) begin bad++; $display("FAIL nt_still_busy got=%0h exp=0", bus.bus_req_ready_o); end
    set_resp(3, 32'hCAFE_0003);
    step(); clr_resp();
    total++; if ({bus.bus_resp_valid_o, bus.bus_resp_error_o, bus.bus_resp_data_o} !== {2'b10, 32'hCAFE_0003}) begin bad++; $display("FAIL nt_late_resp got=%0h exp=%0h", {bus.bus_resp_valid_o, bus.bus_resp_error_o, bus.bus_resp_data_o}, {2'b10, 32'hCAFE_0003}); end
    step();
  endtask
`endif

  initial begin
    test_reset();
    test_read_port1();
    test_unmapped_write();
    test_select_port2();
    test_decode_boundaries();
    test_reset_mid();
    test_back_to_back();
    test_timeout();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
